// File: rtl/gpu_console_driver_if.sv
// gpu_console_driver_if
//   Register bus between the console driver (initiator) and the GPU
//   register block (target). The bus has a single-cycle write strobe and a
//   read strobe whose data returns one cycle later.
//   Signals:
//     bus_addr      [3:0]  register offset
//     bus_data_out  [7:0]  write data, initiator -> GPU
//     bus_data_in   [7:0]  read data, GPU -> initiator
//     bus_we               one-cycle write strobe
//     bus_re               one-cycle read strobe
//   Modports: master (console driver), slave (GPU register block / model).
interface gpu_console_driver_if;
  logic [3:0] bus_addr;
  logic [7:0] bus_data_out;
  logic [7:0] bus_data_in;
  logic       bus_we;
  logic       bus_re;

  modport master (
    output bus_addr, bus_data_out, bus_we, bus_re,
    input  bus_data_in
  );

  modport slave (
    input  bus_addr, bus_data_out, bus_we, bus_re,
    output bus_data_in
  );
endinterface

// File: rtl/gpu_console_driver.sv
// gpu_console_driver
//   Converts a valid/ready stream of ASCII bytes into GPU register writes
//   (cursor row/col, character, control/clear) and tracks the cursor,
//   handling CR, LF, BS, FF, line wrap and page wrap (no scrolling).
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     ch_data/ch_valid    input byte stream; ch_ready is high only in IDLE
//     mode_80col          column limit (0 = 40, 1 = 80), latched per byte
//     bus                 GPU register bus (master modport)
//     cur_row, cur_col    tracked cursor position
//     busy                inverse of ch_ready
//   Build option: define GPU_CONSOLE_STATUS_POLL_EN to poll STATUS bit0
//   before every byte that produces bus traffic. Without it no reads are
//   issued and bus_re is tied low.
module gpu_console_driver #(
  parameter int ROWS      = 30,
  parameter int CURSOR_EN = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  ch_data,
  input  logic                        ch_valid,
  output logic                        ch_ready,
  input  logic                        mode_80col,
  gpu_console_driver_if.master        bus,
  output logic [4:0]                  cur_row,
  output logic [6:0]                  cur_col,
  output logic                        busy
);

  typedef enum logic [2:0] {
    IDLE, POLL_RD, POLL_CHK, WR_ROW, WR_COL, WR_CHAR, WR_CTRL, UPDATE
  } state_t;

  typedef enum logic [1:0] {K_NONE, K_CHAR, K_CTRL} kind_t;

  localparam logic CURSOR_BIT = (CURSOR_EN != 0);

  state_t     state_reg, state_next;
  logic [4:0] row_reg, wrow_reg, frow_reg;
  logic [6:0] col_reg, wcol_reg, fcol_reg;
  logic [7:0] wchar_reg;
  logic       mode_reg;
  logic       ch_ready_reg, busy_reg;
  logic       we_reg, we_next;
  logic [3:0] addr_reg, addr_next;
  logic [7:0] data_reg, data_next;

  function automatic logic [4:0] adv_row(input logic [4:0] r);
    return (r == 5'(ROWS - 1)) ? 5'd0 : r + 5'd1;
  endfunction

  // Plan for the byte currently offered: which writes it needs, their
  // values, and the cursor to commit in UPDATE.
  kind_t      p_kind;
  logic [6:0] lim, pre_col, step_col, p_wcol, p_fcol;
  logic [4:0] pre_row, p_wrow, p_frow;
  logic [7:0] p_wchar;

  always_comb begin
    lim      = mode_80col ? 7'd80 : 7'd40;
    p_kind   = K_NONE;
    pre_row  = row_reg;
    pre_col  = col_reg;
    step_col = 7'd0;
    p_wrow   = row_reg;
    p_wcol   = col_reg;
    p_wchar  = ch_data;
    p_frow   = row_reg;
    p_fcol   = col_reg;
    if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
      // Column beyond the limit happens when the mode shrank from 80 to 40.
      if (col_reg >= lim) begin
        pre_row = adv_row(row_reg);
        pre_col = 7'd0;
      end
      p_kind   = K_CHAR;
      p_wrow   = pre_row;
      p_wcol   = pre_col;
      step_col = pre_col + 7'd1;
      if (step_col == lim) begin
        p_frow = adv_row(pre_row);
        p_fcol = 7'd0;
      end else begin
        p_frow = pre_row;
        p_fcol = step_col;
      end
    end else begin
      case (ch_data)
        8'h0D: p_fcol = 7'd0;
        8'h0A: p_frow = adv_row(row_reg);
        8'h08: begin
          if (col_reg != 7'd0) begin
            p_kind  = K_CHAR;
            p_wcol  = col_reg - 7'd1;
            p_wchar = 8'h20;
            p_fcol  = col_reg - 7'd1;
          end
        end
        8'h0C: begin
          p_kind = K_CTRL;
          p_frow = 5'd0;
          p_fcol = 7'd0;
        end
        default: ;
      endcase
    end
  end

  // In IDLE the plan is still combinational; afterwards the latched copy is used.
  logic       in_idle;
  logic [4:0] s_wrow, s_frow;
  logic [6:0] s_wcol, s_fcol;
  logic [7:0] s_wchar;
  logic       s_mode;

  assign in_idle = (state_reg == IDLE);
  assign s_wrow  = in_idle ? p_wrow     : wrow_reg;
  assign s_wcol  = in_idle ? p_wcol     : wcol_reg;
  assign s_wchar = in_idle ? p_wchar    : wchar_reg;
  assign s_frow  = in_idle ? p_frow     : frow_reg;
  assign s_fcol  = in_idle ? p_fcol     : fcol_reg;
  assign s_mode  = in_idle ? mode_80col : mode_reg;

`ifdef GPU_CONSOLE_STATUS_POLL_EN
  kind_t kind_reg;
  logic  re_reg, re_next;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ch_valid) begin
          case (p_kind)
`ifdef GPU_CONSOLE_STATUS_POLL_EN
            K_CHAR:  state_next = POLL_RD;
            K_CTRL:  state_next = POLL_RD;
`else
            K_CHAR:  state_next = WR_ROW;
            K_CTRL:  state_next = WR_CTRL;
`endif
            default: state_next = UPDATE;
          endcase
        end
      end
`ifdef GPU_CONSOLE_STATUS_POLL_EN
      POLL_RD:  state_next = POLL_CHK;
      // Read data arrives the cycle after the strobe (registered GPU read).
      POLL_CHK: begin
        if (!bus.bus_data_in[0])       state_next = POLL_RD;
        else if (kind_reg == K_CTRL)   state_next = WR_CTRL;
        else                           state_next = WR_ROW;
      end
`endif
      WR_ROW:  state_next = WR_COL;
      WR_COL:  state_next = WR_CHAR;
      WR_CHAR: state_next = UPDATE;
      WR_CTRL: state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they register in the
  // same cycle the state is entered.
  always_comb begin
    we_next   = 1'b0;
    addr_next = 4'd0;
    data_next = 8'd0;
`ifdef GPU_CONSOLE_STATUS_POLL_EN
    re_next   = 1'b0;
`endif
    case (state_next)
`ifdef GPU_CONSOLE_STATUS_POLL_EN
      POLL_RD: begin re_next = 1'b1; addr_next = 4'd6; end
`endif
      WR_ROW:  begin we_next = 1'b1; addr_next = 4'd1; data_next = {3'b0, s_wrow}; end
      WR_COL:  begin we_next = 1'b1; addr_next = 4'd2; data_next = {1'b0, s_wcol}; end
      WR_CHAR: begin we_next = 1'b1; addr_next = 4'd0; data_next = s_wchar; end
      WR_CTRL: begin we_next = 1'b1; addr_next = 4'd3; data_next = {5'b0, CURSOR_BIT, s_mode, 1'b1}; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      row_reg      <= 5'd0;
      col_reg      <= 7'd0;
      wrow_reg     <= 5'd0;
      wcol_reg     <= 7'd0;
      wchar_reg    <= 8'd0;
      frow_reg     <= 5'd0;
      fcol_reg     <= 7'd0;
      mode_reg     <= 1'b0;
      ch_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= 4'd0;
      data_reg     <= 8'd0;
`ifdef GPU_CONSOLE_STATUS_POLL_EN
      kind_reg     <= K_NONE;
      re_reg       <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      ch_ready_reg <= (state_next == IDLE);
      busy_reg     <= (state_next != IDLE);
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
`ifdef GPU_CONSOLE_STATUS_POLL_EN
      re_reg       <= re_next;
`endif
      if (in_idle && ch_valid) begin
        wrow_reg  <= p_wrow;
        wcol_reg  <= p_wcol;
        wchar_reg <= p_wchar;
        frow_reg  <= p_frow;
        fcol_reg  <= p_fcol;
        mode_reg  <= mode_80col;
`ifdef GPU_CONSOLE_STATUS_POLL_EN
        kind_reg  <= p_kind;
`endif
      end
      if (state_next == UPDATE) begin
        row_reg <= s_frow;
        col_reg <= s_fcol;
      end
    end
  end

  assign ch_ready         = ch_ready_reg;
  assign busy             = busy_reg;
  assign cur_row          = row_reg;
  assign cur_col          = col_reg;
  assign bus.bus_we       = we_reg;
  assign bus.bus_addr     = addr_reg;
  assign bus.bus_data_out = data_reg;
`ifdef GPU_CONSOLE_STATUS_POLL_EN
  assign bus.bus_re       = re_reg;
`else
  assign bus.bus_re       = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_console_driver.sv
// tb_gpu_console_driver
//   Directed bench for gpu_console_driver: reset state, character writes,
//   line/page wrap, CR/LF/BS/FF, mode shrink pre-wrap, ignored bytes and
//   (when GPU_CONSOLE_STATUS_POLL_EN is defined) STATUS polling.
module tb_gpu_console_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ch_data = 8'h00;
  logic       ch_valid = 1'b0;
  logic       ch_ready;
  logic       mode_80col = 1'b0;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  logic       busy;

  gpu_console_driver_if bus_if();

  always #5 clk = ~clk;

  gpu_console_driver #(.ROWS(30), .CURSOR_EN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .ch_ready   (ch_ready),
    .mode_80col (mode_80col),
    .bus        (bus_if),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .busy       (busy)
  );

`ifdef GPU_CONSOLE_STATUS_POLL_EN
  localparam int POLL_EXTRA = 2;
`else
  localparam int POLL_EXTRA = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] wr_log [0:1023];
  int wr_total    = 0;
  int re_total    = 0;
  int overlap     = 0;
  int ready_after = 0;

  // Bus monitor: logs every write as {addr, data}, counts reads and overlaps.
  always @(negedge clk) begin
    if (bus_if.bus_we) begin
      if (wr_total < 1024) wr_log[wr_total] = {bus_if.bus_addr, bus_if.bus_data_out};
      wr_total = wr_total + 1;
    end
    if (bus_if.bus_re) re_total = re_total + 1;
    if (bus_if.bus_we && bus_if.bus_re) overlap = overlap + 1;
  end

  // GPU STATUS model: registered read, ready once re_total reaches ready_after.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_if.bus_data_in <= 8'h00;
    else if (bus_if.bus_re) bus_if.bus_data_in <= (re_total >= ready_after) ? 8'h01 : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [3:0] a, input logic [7:0] d);
    check(tag, {20'd0, wr_log[idx]}, {20'd0, a, d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ch_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer one byte, wait for acceptance and for ch_ready to return.
  // lat counts cycles from the accepting edge until ch_ready is seen high.
  task automatic send(input logic [7:0] b, input logic m, output int lat, output int nwr, output int first);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ch_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("ready_timeout", 32'd0, 32'd1);
    #1;
    first = wr_total;
    ch_data = b;
    ch_valid = 1'b1;
    mode_80col = m;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      ch_valid = 1'b0;
      lat++;
    end while (!ch_ready && lat < 100);
    #1;
    nwr = wr_total - first;
    $display("[TB] byte %02h mode %0d lat %0d writes %0d -> row %0d col %0d",
             b, m, lat, nwr, cur_row, cur_col);
  endtask

  initial begin
    int lat, nwr, f, r0;

    // Reset with a byte offered: nothing may happen.
    rst_n = 1'b0;
    ch_valid = 1'b1;
    ch_data = 8'h41;
    repeat (4) @(negedge clk);
    #1;
    check("rst_ready",  {31'd0, ch_ready}, 32'd1);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_we",     {31'd0, bus_if.bus_we}, 32'd0);
    check("rst_re",     {31'd0, bus_if.bus_re}, 32'd0);
    check("rst_addr",   {28'd0, bus_if.bus_addr}, 32'd0);
    check("rst_data",   {24'd0, bus_if.bus_data_out}, 32'd0);
    check("rst_row",    {27'd0, cur_row}, 32'd0);
    check("rst_col",    {25'd0, cur_col}, 32'd0);
    check("rst_nowr",   wr_total, 32'd0);
    @(negedge clk);
    ch_valid = 1'b0;
    rst_n = 1'b1;

    // Single 'A' in 80-column mode.
    send(8'h41, 1'b1, lat, nwr, f);
    check("A_lat", lat, 5 + POLL_EXTRA);
    check("A_nwr", nwr, 3);
    check_wr("A_wr_row",  f,     4'd1, 8'h00);
    check_wr("A_wr_col",  f + 1, 4'd2, 8'h00);
    check_wr("A_wr_char", f + 2, 4'd0, 8'h41);
    check("A_col", {25'd0, cur_col}, 32'd1);
    check("A_row", {27'd0, cur_row}, 32'd0);

    // Line wrap in 40-column mode.
    do_reset();
    for (int i = 0; i < 40; i++) send(8'h41, 1'b0, lat, nwr, f);
    check("wrap_nwr",   nwr, 3);
    check_wr("wrap_lastcol", f + 1, 4'd2, 8'd39);
    check("wrap_row", {27'd0, cur_row}, 32'd1);
    check("wrap_col", {25'd0, cur_col}, 32'd0);

    // Page wrap from row 29 col 39.
    for (int i = 0; i < 28; i++) send(8'h0A, 1'b0, lat, nwr, f);
    check("lf_row29", {27'd0, cur_row}, 32'd29);
    for (int i = 0; i < 39; i++) send(8'h41, 1'b0, lat, nwr, f);
    check("pre_page_col", {25'd0, cur_col}, 32'd39);
    send(8'h41, 1'b0, lat, nwr, f);
    check_wr("page_wr_row", f,     4'd1, 8'd29);
    check_wr("page_wr_col", f + 1, 4'd2, 8'd39);
    check("page_row", {27'd0, cur_row}, 32'd0);
    check("page_col", {25'd0, cur_col}, 32'd0);

    // CR, LF, BS.
    do_reset();
    send(8'h41, 1'b1, lat, nwr, f);
    send(8'h42, 1'b1, lat, nwr, f);
    send(8'h0D, 1'b1, lat, nwr, f);
    check("cr_lat", lat, 2);
    check("cr_nwr", nwr, 0);
    check("cr_col", {25'd0, cur_col}, 32'd0);
    check("cr_row", {27'd0, cur_row}, 32'd0);
    send(8'h0A, 1'b1, lat, nwr, f);
    check("lf_row", {27'd0, cur_row}, 32'd1);
    check("lf_col", {25'd0, cur_col}, 32'd0);
    check("lf_nwr", nwr, 0);
    for (int i = 0; i < 5; i++) send(8'h41, 1'b1, lat, nwr, f);
    check("col5", {25'd0, cur_col}, 32'd5);
    send(8'h08, 1'b1, lat, nwr, f);
    check("bs_lat", lat, 5 + POLL_EXTRA);
    check("bs_nwr", nwr, 3);
    check_wr("bs_wr_row",  f,     4'd1, 8'd1);
    check_wr("bs_wr_col",  f + 1, 4'd2, 8'd4);
    check_wr("bs_wr_char", f + 2, 4'd0, 8'h20);
    check("bs_col", {25'd0, cur_col}, 32'd4);
    send(8'h0D, 1'b1, lat, nwr, f);
    send(8'h08, 1'b1, lat, nwr, f);
    check("bs0_nwr", nwr, 0);
    check("bs0_lat", lat, 2);
    check("bs0_col", {25'd0, cur_col}, 32'd0);

    // Form feed clears and homes the cursor.
    send(8'h0C, 1'b1, lat, nwr, f);
    check("ff_lat", lat, 3 + POLL_EXTRA);
    check("ff_nwr", nwr, 1);
    check_wr("ff_wr", f, 4'd3, 8'h07);
    check("ff_row", {27'd0, cur_row}, 32'd0);
    check("ff_col", {25'd0, cur_col}, 32'd0);

    // Mode shrink: col 45 then a 40-column character wraps first.
    for (int i = 0; i < 45; i++) send(8'h41, 1'b1, lat, nwr, f);
    check("col45", {25'd0, cur_col}, 32'd45);
    send(8'h5A, 1'b0, lat, nwr, f);
    check_wr("shrink_wr_row",  f,     4'd1, 8'd1);
    check_wr("shrink_wr_col",  f + 1, 4'd2, 8'd0);
    check_wr("shrink_wr_char", f + 2, 4'd0, 8'h5A);
    check("shrink_row", {27'd0, cur_row}, 32'd1);
    check("shrink_col", {25'd0, cur_col}, 32'd1);

    // Ignored byte.
    send(8'h01, 1'b1, lat, nwr, f);
    check("ign_lat", lat, 2);
    check("ign_nwr", nwr, 0);
    check("ign_col", {25'd0, cur_col}, 32'd1);

`ifdef GPU_CONSOLE_STATUS_POLL_EN
    // STATUS not ready for three reads, ready on the fourth.
    r0 = re_total;
    ready_after = re_total + 4;
    send(8'h43, 1'b1, lat, nwr, f);
    ready_after = 0;
    check("poll_reads", re_total - r0, 4);
    check("poll_lat", lat, 13);
    check("poll_nwr", nwr, 3);
    check_wr("poll_wr_row",  f,     4'd1, 8'd1);
    check_wr("poll_wr_col",  f + 1, 4'd2, 8'd1);
    check_wr("poll_wr_char", f + 2, 4'd0, 8'h43);
    check("poll_col", {25'd0, cur_col}, 32'd2);
`else
    r0 = 0;
    check("no_reads", re_total, r0);
`endif
    check("we_re_overlap", overlap, 0);
    check("idle_we", {31'd0, bus_if.bus_we}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gpu_console_driver.md
# gpu_console_driver

Hardware console front end that drives the GPU's CPU-side register bus as a bus initiator. It accepts a valid/ready stream of ASCII bytes (e.g. from a UART receiver or debug monitor) and turns each byte into register writes to the GPU register block: cursor positioning, character writes and screen clear. It tracks the cursor itself, handling carriage return, line feed, backspace, form feed, line wrap and page wrap. This lets text reach the display without CPU involvement.

## Interface

Parameters:
- `ROWS`, default 30, text rows; the last row index is ROWS-1.
- `CURSOR_EN`, default 1, value driven into CONTROL bit2 on clear.

Ports:
- `clk`  in  1  system clock; same domain as the GPU register bus.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ch_data`  in  8  ASCII byte.
- `ch_valid`  in  1  ch_data valid.
- `ch_ready`  out  1  block can accept a byte.
- `mode_80col`  in  1  column limit; 0 = 40 columns, 1 = 80 columns.
- `bus_addr`  out  4  GPU register offset.
- `bus_data_out`  out  8  write data to GPU.
- `bus_data_in`  in  8  read data from GPU.
- `bus_we`  out  1  one-cycle write strobe.
- `bus_re`  out  1  one-cycle read strobe.
- `cur_row`  out  5  tracked cursor row.
- `cur_col`  out  7  tracked cursor column.
- `busy`  out  1  equal to !ch_ready.

## Operation

Register offsets used: 0 CHAR_DATA, 1 CURSOR_ROW, 2 CURSOR_COL, 3 CONTROL, 6 STATUS (bit0 = ready). CONTROL bits: bit0 clear, bit1 mode_80col, bit2 cursor enable.

Byte transfer:
- A byte is accepted when ch_valid and ch_ready are both high.
- ch_data and mode_80col are latched at acceptance.
- The column limit is LIM = 80 when mode_80col = 1, otherwise 40.

Byte handling:
- 0x20-0x7E, printable:
  - If cur_col ≥ LIM (mode was shrunk), first set col = 0 and advance the row.
  - Then write ROW, write COL, write CHAR.
  - Then col = col + 1. If col reaches LIM: col = 0 and advance the row.
- 0x0D, CR: col = 0. No bus traffic.
- 0x0A, LF: advance the row. Column unchanged. No bus traffic.
- 0x08, BS:
  - If col > 0: col = col − 1, then write ROW, COL, CHAR = 0x20. Cursor stays at the new col.
  - If col = 0: no-op.
- 0x0C, FF: write CONTROL = {5'b0, CURSOR_EN, mode, 1'b1}. Then row = 0, col = 0.
- Any other byte is consumed with no effect.

Advancing the row: row + 1; from ROWS−1 it wraps to 0 (page mode, no scroll).

State machine:
- States: IDLE, POLL_RD, POLL_CHK, WR_ROW, WR_COL, WR_CHAR, WR_CTRL, UPDATE.
- IDLE → (POLL_RD if polling is compiled in and the byte needs bus traffic, else the first write state or UPDATE).
- POLL_RD → POLL_CHK.
- POLL_CHK → POLL_RD if bit0 = 0, else the first write state.
- WR_ROW → WR_COL → WR_CHAR → UPDATE.
- WR_CTRL → UPDATE.
- UPDATE → IDLE.

Outputs:
- ch_ready is high only in IDLE.
- cur_row and cur_col change only in UPDATE, except for the pre-wrap case: the pre-wrap row/col values are used for the bus writes but are committed in UPDATE.

## Timing

- All outputs are registered.
- Reset values: ch_ready = 1, busy = 0, bus_we = 0, bus_re = 0, bus_addr = 0, bus_data_out = 0, cur_row = 0, cur_col = 0, state = IDLE.
- Each write is exactly one cycle with bus_we = 1 and addr/data stable in that cycle. Consecutive writes are back-to-back.
- Read: bus_re is high for one cycle (POLL_RD). bus_data_in is sampled on the following cycle (POLL_CHK), matching the GPU's registered read.
- bus_we and bus_re are never high together.
- Printable or BS byte, polling off, accepted at edge T:
  - bus_we high in cycles T+1, T+2, T+3.
  - Cursor updated at T+4.
  - ch_ready high at T+5.
- FF, polling off: bus_we at T+1, cursor updated at T+2, ready at T+3.
- CR, LF and ignored bytes: UPDATE at T+1, ready at T+2.
- Polling adds 2 cycles per STATUS read.
- rst_n asserted mid-sequence aborts it immediately. Outputs return to their reset values and any partially written sequence is not resumed.

## Configuration

- `GPU_CONSOLE_STATUS_POLL_EN`
  - Defined: every byte that produces bus traffic first polls STATUS until bit0 = 1.
  - Undefined: no reads are issued, bus_re is tied to 0, and bus_data_in is ignored.

## Test plan

- Reset: hold rst_n low with ch_valid = 1 → all outputs at their reset values; no strobes.
- Write 'A' (0x41), mode_80col = 1, polling off → (addr 1, data 0x00), (addr 2, data 0x00), (addr 0, data 0x41) on consecutive cycles; cur_col = 1; ch_ready returns 5 cycles after acceptance.
- Wrap, mode_80col = 0:
  - 40 × 0x41 → the last write has COL = 39; cursor ends at row 1, col 0.
  - From row 29, col 39, one more char → cursor ends at row 0, col 0.
- Controls:
  - "AB\r" → col 0, row 0.
  - Then 0x0A → row 1.
  - At col 5, 0x08 → writes ROW, COL = 4, CHAR = 0x20; cur_col = 4.
  - At col 0, 0x08 → no strobes.
- FF with mode_80col = 1, CURSOR_EN = 1 → single write (addr 3, data 0x07); cursor 0,0.
- Polling enabled: STATUS returns 0x00 three times, then 0x01 → four bus_re pulses, then the three writes. Also check bus_we never overlaps bus_re.
